// File: rtl/step_controller.sv
// Purpose: processor single-step / burst / free-run clock controller with a halt input.
// Latency: a step decision registers ProcEnable, ProcClock and Mode one cycle after the triggering input.
// Backpressure: HaltIn stops stepping; strobes arriving while ProcClock is high are dropped.
module step_controller #(
    parameter int PRESCALE_W = 24,
    parameter int PULSE_LEN  = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        StepStrobe,
    input  logic        RunSwitch,
    input  logic        BurstSwitch,
    input  logic [7:0]  BurstCount,
    input  logic [1:0]  RateSel,
    input  logic        HaltIn,
    output logic        ProcEnable,
    output logic        ProcClock,
    output logic [15:0] StepCount,
    output logic [2:0]  Mode
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STEP   = 3'd1,
        S_RUN    = 3'd2,
        S_BURST  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    // Pulse counter only needs to hold PULSE_LEN-1.
    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    state_t                  state_q, state_d;
    logic [PRESCALE_W-1:0]   presc_q, presc_d;
    logic [1:0]              rate_q, rate_d;
    logic [7:0]              remain_q, remain_d;
    logic [PW-1:0]           pulse_q, pulse_d;
    logic                    proc_en_q, proc_en_d;
    logic                    proc_clk_q, proc_clk_d;
    logic [15:0]             step_cnt_q, step_cnt_d;

    logic                    step_issue;
    logic                    strobe_ok;
    logic [PRESCALE_W-1:0]   term_val;

    // A strobe seen while the processor clock is still high belongs to the previous step.
    assign strobe_ok = StepStrobe && !proc_clk_q;

    // Period is 2^(PRESCALE_W - 2*rate); the rate is latched per step so a
    // mid-period RateSel change can never shorten the period in progress.
    assign term_val = {PRESCALE_W{1'b1}} >> {rate_q, 1'b0};

    // Next-state decode; step_issue marks the cycle whose edge issues a step.
    // remain_q counts steps still owed after the one being issued.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        rate_d     = rate_q;
        remain_d   = remain_q;
        step_issue = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (HaltIn) begin
                    state_d = S_HALTED;
                end else if (strobe_ok) begin
                    if (!BurstSwitch) begin
                        state_d    = S_STEP;
                        step_issue = 1'b1;
                    end else if (BurstCount != 8'd0) begin
                        state_d    = S_BURST;
                        step_issue = 1'b1;
                        remain_d   = BurstCount - 8'd1;
                    end
                end else if (RunSwitch && !proc_clk_q) begin
                    state_d    = S_RUN;
                    step_issue = 1'b1;
                end
            end
            S_STEP: begin
                state_d = HaltIn ? S_HALTED : S_IDLE;
            end
            S_RUN: begin
                if (HaltIn) begin
                    state_d = S_HALTED;
                end else if (!RunSwitch) begin
                    state_d = S_IDLE;
                end else if (presc_q == term_val) begin
                    step_issue = 1'b1;
                    presc_d    = '0;
                end else begin
                    presc_d = presc_q + PRESCALE_W'(1);
                end
            end
            S_BURST: begin
                if (HaltIn) begin
                    state_d = S_HALTED;
                end else if (strobe_ok) begin
                    state_d  = S_IDLE;
                    remain_d = 8'd0;
                end else if (remain_q == 8'd0) begin
                    state_d = S_IDLE;
                end else if (presc_q == term_val) begin
                    step_issue = 1'b1;
                    presc_d    = '0;
                    remain_d   = remain_q - 8'd1;
                end else begin
                    presc_d = presc_q + PRESCALE_W'(1);
                end
            end
            S_HALTED: begin
                if (strobe_ok && !HaltIn && !RunSwitch) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Prescaler restarts on every state change so the first step of a
        // RUN/BURST lands in the entry cycle and the next one a full period later.
        if (state_d != state_q) begin
            presc_d = '0;
        end
        if (state_d == S_IDLE || state_d == S_HALTED) begin
            remain_d = 8'd0;
        end
        if (step_issue) begin
            rate_d = RateSel;
        end
    end

    // Output pulse shaping and the step counter.
    always_comb begin
        proc_en_d  = step_issue;
        pulse_d    = pulse_q;
        proc_clk_d = 1'b0;
        step_cnt_d = step_cnt_q;
        if (step_issue) begin
            pulse_d    = PW'(PULSE_LEN - 1);
            proc_clk_d = 1'b1;
            step_cnt_d = step_cnt_q + 16'd1;
        end else if (pulse_q != '0) begin
            pulse_d    = pulse_q - PW'(1);
            proc_clk_d = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            rate_q     <= 2'd0;
            remain_q   <= 8'd0;
            pulse_q    <= '0;
            proc_en_q  <= 1'b0;
            proc_clk_q <= 1'b0;
            step_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            rate_q     <= rate_d;
            remain_q   <= remain_d;
            pulse_q    <= pulse_d;
            proc_en_q  <= proc_en_d;
            proc_clk_q <= proc_clk_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign ProcEnable = proc_en_q;
    assign ProcClock  = proc_clk_q;
    assign StepCount  = step_cnt_q;
    assign Mode       = state_q;

endmodule

// File: doc/step_controller.md
STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 Parameter PRESCALE_W, default 24: prescaler width; run-rate period = 2^(PRESCALE_W - 2*RateSel) clock cycles; SHALL be >= 10.
REQ-002 Parameter PULSE_LEN, default 4: ProcClock high time in cycles; SHALL be >= 1 and < 2^(PRESCALE_W-6).
REQ-003 Port Clock  input  1: single system clock (50 MHz board clock); all state updates on rising edge.
REQ-004 Port Reset  input  1: synchronous, active-high reset.
REQ-005 Port StepStrobe  input  1: one-cycle pulse from the debounced step key.
REQ-006 Port RunSwitch  input  1: level; 1 requests free-run mode.
REQ-007 Port BurstSwitch  input  1: level; 1 makes StepStrobe start a burst instead of a single step.
REQ-008 Port BurstCount  input  8: number of steps per burst, sampled on burst start.
REQ-009 Port RateSel  input  2: run/burst rate select, sampled continuously.
REQ-010 Port HaltIn  input  1: level from the processor; 1 stops all stepping.
REQ-011 Port ProcEnable  output  1: one-cycle pulse per processor step.
REQ-012 Port ProcClock  output  1: processor clock; high PULSE_LEN cycles starting with each ProcEnable pulse.
REQ-013 Port StepCount  output  16: total steps issued since reset.
REQ-014 Port Mode  output  3: current state encoding (IDLE=0, STEP=1, RUN=2, BURST=3, HALTED=4).

Function
REQ-015 All outputs SHALL be registered; ProcEnable SHALL be high exactly in the cycle a step is issued, and ProcClock SHALL rise in that same cycle.
REQ-016 IDLE: StepStrobe with BurstSwitch=0 SHALL enter STEP; StepStrobe with BurstSwitch=1 and BurstCount!=0 SHALL enter BURST with remaining=BurstCount; BurstCount=0 SHALL leave the FSM in IDLE with no step; RunSwitch=1 with no StepStrobe SHALL enter RUN.
REQ-017 StepStrobe sampled in IDLE at cycle n SHALL issue the first step (STEP or BURST) at cycle n+1.
REQ-018 STEP: issue one step, return to IDLE next cycle.
REQ-019 RUN/BURST: first step SHALL be issued in the first cycle in the state; subsequent steps every period cycles (REQ-001); prescaler SHALL restart at each state entry.
REQ-020 RUN: RunSwitch=0 SHALL return to IDLE next cycle with no further step.
REQ-021 BURST: remaining SHALL decrement per step; after the step that makes remaining 0, the FSM SHALL return to IDLE; StepStrobe during BURST SHALL abort to IDLE with no further step.
REQ-022 HaltIn=1 in any non-HALTED state SHALL enter HALTED next cycle and suppress any step in that cycle; HALTED issues no steps.
REQ-023 HALTED SHALL exit to IDLE only on StepStrobe with HaltIn=0 and RunSwitch=0; that strobe SHALL NOT issue a step.
REQ-024 Priority per cycle: Reset > HaltIn > StepStrobe abort > RunSwitch/step decode.
REQ-025 StepStrobe arriving while ProcClock is high from a previous step SHALL be ignored.
REQ-026 StepCount SHALL increment by 1 per ProcEnable pulse, wrapping 0xFFFF -> 0x0000.
REQ-027 RateSel change mid-run SHALL take effect from the next prescaler restart or wrap; no step SHALL be issued sooner than 2^(PRESCALE_W-6) cycles after the previous one.

Reset
REQ-028 On Reset: Mode=IDLE, ProcEnable=0, ProcClock=0, StepCount=0, remaining=0, prescaler=0.
REQ-029 Reset asserted mid-burst or mid-pulse SHALL drop ProcClock to 0 in the next cycle and discard the burst.
REQ-030 Inputs held during Reset SHALL be ignored; the first transition is evaluated on the first cycle with Reset=0.

Verification (PRESCALE_W=10, PULSE_LEN=4)
REQ-031 IDLE, StepStrobe at cycle 10 -> ProcEnable=1 only at cycle 11, ProcClock high cycles 11-14, StepCount=1, Mode back to 0 at cycle 12.
REQ-032 BurstSwitch=1, BurstCount=3, RateSel=2, StepStrobe -> exactly 3 ProcEnable pulses spaced 64 cycles, StepCount=3, then Mode=IDLE; BurstCount=0 -> no pulses.
REQ-033 RunSwitch=1, RateSel=3 -> pulses every 16 cycles; HaltIn=1 -> Mode=HALTED next cycle, no pulses; StepStrobe with HaltIn=0, RunSwitch=0 -> IDLE, StepCount unchanged.
REQ-034 Burst of 200, StepStrobe after 5th step -> exactly 5 steps, Mode=IDLE.
REQ-035 Preload via 65535 steps in RUN, one more step -> StepCount=0x0000.
REQ-036 Reset during ProcClock high in RUN -> ProcClock=0, StepCount=0, Mode=IDLE next cycle.
